// File: rtl/mmio_pkg.sv
// ============================================================================
// Module   : mmio_pkg
// Purpose  : Register offsets and bit positions shared by the MMIO timer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

    // Word offsets inside the 8-word decode window
    localparam logic [2:0] c_off_ctrl  = 3'd0;
    localparam logic [2:0] c_off_pre   = 3'd1;
    localparam logic [2:0] c_off_load  = 3'd2;
    localparam logic [2:0] c_off_count = 3'd3;
    localparam logic [2:0] c_off_stat  = 3'd4;

    localparam int c_ctrl_en     = 0;
    localparam int c_ctrl_reload = 1;
    localparam int c_ctrl_ie     = 2;
    localparam int c_ctrl_bits   = 3;

    localparam int c_stat_exp    = 0;

endpackage : mmio_pkg

`default_nettype wire

// File: rtl/mmio_timer_tick_gen.sv
// ============================================================================
// Module   : tick_gen
// Purpose  : Prescaler; emits one tick every pre+1 enabled clocks.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] pre,
    output logic             tick
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             w_match;

    assign w_match = (cnt_q == pre);
    assign tick    = en && w_match;

    // Equality compare: a PRE shrunk below the running count wraps through 2^WIDTH
    always_comb begin
        cnt_d = cnt_q;
        if (!en || clr) begin
            cnt_d = '0;
        end else if (w_match) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + c_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_gen

`default_nettype wire

// File: rtl/mmio_timer.sv
// ============================================================================
// Module   : mmio_timer
// Purpose  : Memory-mapped down-counting timer with sticky expiry and level irq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_timer
    import mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hC010,
    parameter int          WIDTH     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic        re,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        irq
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [c_ctrl_bits-1:0] ctrl_q,  ctrl_d;
    logic [WIDTH-1:0]       pre_q,   pre_d;
    logic [WIDTH-1:0]       load_q,  load_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic                   exp_q,   exp_d;

    logic       w_hit;
    logic [2:0] w_off;
    logic       w_wr_ctrl;
    logic       w_wr_pre;
    logic       w_wr_load;
    logic       w_wr_count;
    logic       w_wr_stat;
    logic       w_tick;
    logic       w_tick_eff;
    logic       w_expire;
    logic       w_pre_clr;

    assign w_hit      = (addr[15:3] == BASE_ADDR[15:3]);
    assign w_off      = addr[2:0];
    assign w_wr_ctrl  = we && w_hit && (w_off == c_off_ctrl);
    assign w_wr_pre   = we && w_hit && (w_off == c_off_pre);
    assign w_wr_load  = we && w_hit && (w_off == c_off_load);
    assign w_wr_count = we && w_hit && (w_off == c_off_count);
    assign w_wr_stat  = we && w_hit && (w_off == c_off_stat);

    // Restart the prescaler on an EN rising write so the first tick is a full period away
    assign w_pre_clr = w_wr_ctrl && wdata[c_ctrl_en] && !ctrl_q[c_ctrl_en];

    tick_gen #(
        .WIDTH (WIDTH)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (ctrl_q[c_ctrl_en]),
        .clr  (w_pre_clr),
        .pre  (pre_q),
        .tick (w_tick)
    );

    // A tick is dropped when firmware disables the timer or rewrites COUNT on that edge
    assign w_tick_eff = w_tick
                        && !(w_wr_ctrl && !wdata[c_ctrl_en])
                        && !w_wr_count;
    assign w_expire   = w_tick_eff && (count_q == '0);

    always_comb begin
        ctrl_d  = ctrl_q;
        pre_d   = pre_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;

        if (w_wr_ctrl) begin
            ctrl_d = wdata[c_ctrl_bits-1:0];
        end
        if (w_wr_pre) begin
            pre_d = wdata[WIDTH-1:0];
        end
        if (w_wr_load) begin
            load_d = wdata[WIDTH-1:0];
        end

        if (w_wr_count) begin
            count_d = wdata[WIDTH-1:0];
        end else if (w_tick_eff) begin
            if (count_q != '0) begin
                count_d = count_q - c_one;
            end else if (ctrl_q[c_ctrl_reload]) begin
                count_d = load_q;
            end else begin
                count_d           = '0;
                ctrl_d[c_ctrl_en] = 1'b0;
            end
        end

        // Set has priority over a same-cycle W1C
        if (w_wr_stat && wdata[c_stat_exp]) begin
            exp_d = 1'b0;
        end
        if (w_expire) begin
            exp_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            pre_q   <= '0;
            load_q  <= '0;
            count_q <= '0;
            exp_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            pre_q   <= pre_d;
            load_q  <= load_d;
            count_q <= count_d;
            exp_q   <= exp_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (re && w_hit) begin
            case (w_off)
                c_off_ctrl:  rdata[c_ctrl_bits-1:0] = ctrl_q;
                c_off_pre:   rdata[WIDTH-1:0]       = pre_q;
                c_off_load:  rdata[WIDTH-1:0]       = load_q;
                c_off_count: rdata[WIDTH-1:0]       = count_q;
                c_off_stat:  rdata[c_stat_exp]      = exp_q;
                default:     rdata                  = '0;
            endcase
        end
    end

    assign irq = exp_q & ctrl_q[c_ctrl_ie];

endmodule : mmio_timer

`default_nettype wire
